// File: rtl/dlx_id_control.sv
// DLX ID-stage control: decodes IF/ID, registers the control set into ID/EX,
// and owns load-use stalls, multiply holds and taken-branch squashing.
module dlx_id_control #(
    parameter int MUL_CYCLES = 4,
    parameter bit HAZARD_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:31] id_instr,
    input  logic        id_valid,
    input  logic        ex_taken,
    output logic        if_stall,
    output logic        mul_busy,
    output logic        ex_valid,
    output logic        PCtoReg,
    output logic        regToPC,
    output logic        jump,
    output logic        branch,
    output logic        branchZero,
    output logic        RType,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        MemWrite,
    output logic        loadSign,
    output logic        mul,
    output logic        extOp,
    output logic        LHIOp,
    output logic [0:1]  DSize,
    output logic [0:3]  ALUCtrl,
    output logic [0:4]  ex_dest,
    output logic [0:4]  ex_rs1,
    output logic [0:4]  ex_rs2
);

    localparam int CW = $clog2(MUL_CYCLES) + 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_SLT = 4'b0010,
                           ALU_SLE = 4'b0011, ALU_SGT = 4'b0100, ALU_SGE = 4'b0101,
                           ALU_SRA = 4'b0111, ALU_SLL = 4'b1001, ALU_SRL = 4'b1010,
                           ALU_SEQ = 4'b1011, ALU_SNE = 4'b1100, ALU_AND = 4'b1101,
                           ALU_OR  = 4'b1110, ALU_XOR = 4'b1111;

    localparam logic [1:0] DS_BYTE = 2'b01, DS_HALF = 2'b10, DS_WORD = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_FP    = 6'h01, OP_J     = 6'h02,
                           OP_JAL   = 6'h03, OP_BEQZ  = 6'h04, OP_BNEZ  = 6'h05,
                           OP_ADDI  = 6'h08, OP_ADDUI = 6'h09, OP_SUBI  = 6'h0A,
                           OP_SUBUI = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D,
                           OP_XORI  = 6'h0E, OP_LHI   = 6'h0F, OP_JR    = 6'h12,
                           OP_JALR  = 6'h13, OP_SLLI  = 6'h14, OP_SRLI  = 6'h16,
                           OP_SRAI  = 6'h17, OP_SEQI  = 6'h18, OP_SNEI  = 6'h19,
                           OP_SLTI  = 6'h1A, OP_SGTI  = 6'h1B, OP_SLEI  = 6'h1C,
                           OP_SGEI  = 6'h1D, OP_LB    = 6'h20, OP_LH    = 6'h21,
                           OP_LW    = 6'h23, OP_LBU   = 6'h24, OP_LHU   = 6'h25,
                           OP_SB    = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h04, F_SRL = 6'h06, F_SRA = 6'h07, F_ADD = 6'h20,
                           F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                           F_OR = 6'h25, F_XOR = 6'h26, F_SEQ = 6'h28, F_SNE = 6'h29,
                           F_SLT = 6'h2A, F_SGT = 6'h2B, F_SLE = 6'h2C, F_SGE = 6'h2D;

    localparam logic [4:0] FF_MULT = 5'h0E, FF_MULTU = 5'h16;

    typedef struct packed {
        logic       pc_to_reg;
        logic       reg_to_pc;
        logic       jump;
        logic       branch;
        logic       branch_zero;
        logic       r_type;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       load_sign;
        logic       mul;
        logic       ext_op;
        logic       lhi_op;
        logic [1:0] dsize;
        logic [3:0] alu_ctrl;
    } ctrl_t;

    logic [5:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic [5:0] func;
    logic [4:0] fp_func;
    logic       unused_shamt;

    assign opcode       = id_instr[0:5];
    assign rs1          = id_instr[6:10];
    assign rs2          = id_instr[11:15];
    assign rd           = id_instr[16:20];
    assign func         = id_instr[26:31];
    assign fp_func      = id_instr[27:31];
    assign unused_shamt = ^id_instr[21:25];

    ctrl_t      dec, cap_ctrl, ex_ctrl_q;
    logic [4:0] dec_dest;
    logic       use_rs1, use_rs2, is_imm;
    logic       ex_valid_q;
    logic [4:0] ex_dest_q, ex_rs1_q, ex_rs2_q;
    logic [CW-1:0] mul_cnt;
    logic       hazard;

    always_comb begin
        dec      = '0;
        dec_dest = '0;
        use_rs1  = 1'b1;
        use_rs2  = 1'b0;
        is_imm   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec.r_type    = 1'b1;
                dec.reg_write = 1'b1;
                dec_dest      = rd;
                use_rs2       = 1'b1;
                case (func)
                    F_SLL:         dec.alu_ctrl = ALU_SLL;
                    F_SRL:         dec.alu_ctrl = ALU_SRL;
                    F_SRA:         dec.alu_ctrl = ALU_SRA;
                    F_ADD, F_ADDU: dec.alu_ctrl = ALU_ADD;
                    F_SUB, F_SUBU: dec.alu_ctrl = ALU_SUB;
                    F_AND:         dec.alu_ctrl = ALU_AND;
                    F_OR:          dec.alu_ctrl = ALU_OR;
                    F_XOR:         dec.alu_ctrl = ALU_XOR;
                    F_SEQ:         dec.alu_ctrl = ALU_SEQ;
                    F_SNE:         dec.alu_ctrl = ALU_SNE;
                    F_SLT:         dec.alu_ctrl = ALU_SLT;
                    F_SGT:         dec.alu_ctrl = ALU_SGT;
                    F_SLE:         dec.alu_ctrl = ALU_SLE;
                    F_SGE:         dec.alu_ctrl = ALU_SGE;
                    default:       dec.alu_ctrl = ALU_ADD;
                endcase
            end
            OP_FP: begin
                dec.r_type    = 1'b1;
                dec.reg_write = 1'b1;
                dec_dest      = rd;
                use_rs2       = 1'b1;
                dec.mul       = (fp_func == FF_MULT) || (fp_func == FF_MULTU);
            end
            OP_J: begin
                dec.jump = 1'b1;
                use_rs1  = 1'b0;
            end
            OP_JAL: begin
                dec.jump      = 1'b1;
                dec.pc_to_reg = 1'b1;
                dec.reg_write = 1'b1;
                dec_dest      = 5'd31;
                use_rs1       = 1'b0;
            end
            OP_JR: begin
                dec.jump      = 1'b1;
                dec.reg_to_pc = 1'b1;
            end
            OP_JALR: begin
                dec.jump      = 1'b1;
                dec.reg_to_pc = 1'b1;
                dec.pc_to_reg = 1'b1;
                dec.reg_write = 1'b1;
                dec_dest      = 5'd31;
            end
            OP_BEQZ: begin
                dec.branch      = 1'b1;
                dec.branch_zero = 1'b1;
                dec.ext_op      = 1'b1;
            end
            OP_BNEZ: begin
                dec.branch = 1'b1;
                dec.ext_op = 1'b1;
            end
            OP_LHI: begin
                dec.lhi_op = 1'b1;
                is_imm     = 1'b1;
                use_rs1    = 1'b0;
            end
            OP_ADDI:  begin is_imm = 1'b1; dec.ext_op = 1'b1; end
            OP_ADDUI: is_imm = 1'b1;
            OP_SUBI:  begin is_imm = 1'b1; dec.ext_op = 1'b1; dec.alu_ctrl = ALU_SUB; end
            OP_SUBUI: begin is_imm = 1'b1; dec.alu_ctrl = ALU_SUB; end
            OP_ANDI:  begin is_imm = 1'b1; dec.alu_ctrl = ALU_AND; end
            OP_ORI:   begin is_imm = 1'b1; dec.alu_ctrl = ALU_OR; end
            OP_XORI:  begin is_imm = 1'b1; dec.alu_ctrl = ALU_XOR; end
            OP_SLLI:  begin is_imm = 1'b1; dec.alu_ctrl = ALU_SLL; end
            OP_SRLI:  begin is_imm = 1'b1; dec.alu_ctrl = ALU_SRL; end
            OP_SRAI:  begin is_imm = 1'b1; dec.alu_ctrl = ALU_SRA; end
            OP_SEQI:  begin is_imm = 1'b1; dec.ext_op = 1'b1; dec.alu_ctrl = ALU_SEQ; end
            OP_SNEI:  begin is_imm = 1'b1; dec.ext_op = 1'b1; dec.alu_ctrl = ALU_SNE; end
            OP_SLTI:  begin is_imm = 1'b1; dec.ext_op = 1'b1; dec.alu_ctrl = ALU_SLT; end
            OP_SGTI:  begin is_imm = 1'b1; dec.ext_op = 1'b1; dec.alu_ctrl = ALU_SGT; end
            OP_SLEI:  begin is_imm = 1'b1; dec.ext_op = 1'b1; dec.alu_ctrl = ALU_SLE; end
            OP_SGEI:  begin is_imm = 1'b1; dec.ext_op = 1'b1; dec.alu_ctrl = ALU_SGE; end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.ext_op     = 1'b1;
                dec_dest       = rs2;
                dec.load_sign  = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW);
                dec.dsize      = (opcode == OP_LB || opcode == OP_LBU) ? DS_BYTE :
                                 (opcode == OP_LH || opcode == OP_LHU) ? DS_HALF : DS_WORD;
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.mem_write = 1'b1;
                dec.ext_op    = 1'b1;
                use_rs2       = 1'b1;
                dec.dsize     = (opcode == OP_SB) ? DS_BYTE :
                                (opcode == OP_SH) ? DS_HALF : DS_WORD;
            end
            default: ;
        endcase
        if (is_imm) begin
            dec.reg_write = 1'b1;
            dec_dest      = rs2;
        end
    end

    // An invalid slot must never commit architectural state or redirect fetch.
    always_comb begin
        cap_ctrl = dec;
        if (!id_valid) begin
            cap_ctrl.reg_write = 1'b0;
            cap_ctrl.mem_write = 1'b0;
            cap_ctrl.jump      = 1'b0;
            cap_ctrl.branch    = 1'b0;
        end
    end

    assign hazard = HAZARD_EN && ex_valid_q && ex_ctrl_q.mem_to_reg && id_valid &&
                    (ex_dest_q != 5'd0) &&
                    ((use_rs1 && (rs1 == ex_dest_q)) || (use_rs2 && (rs2 == ex_dest_q)));

    assign mul_busy = (mul_cnt != '0);
    assign if_stall = mul_busy || (hazard && !ex_taken);

    // Priority: multiply hold, then squash, then load-use bubble, then normal issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_dest_q  <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            mul_cnt    <= '0;
        end else if (mul_busy) begin
            mul_cnt <= mul_cnt - 1'b1;
        end else if (ex_taken || hazard) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_dest_q  <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
        end else begin
            ex_valid_q <= id_valid;
            ex_ctrl_q  <= cap_ctrl;
            ex_dest_q  <= dec_dest;
            ex_rs1_q   <= rs1;
            ex_rs2_q   <= rs2;
            if (id_valid && dec.mul) begin
                mul_cnt <= MUL_LOAD;
            end
        end
    end

    assign ex_valid   = ex_valid_q;
    assign PCtoReg    = ex_ctrl_q.pc_to_reg;
    assign regToPC    = ex_ctrl_q.reg_to_pc;
    assign jump       = ex_ctrl_q.jump;
    assign branch     = ex_ctrl_q.branch;
    assign branchZero = ex_ctrl_q.branch_zero;
    assign RType      = ex_ctrl_q.r_type;
    assign RegWrite   = ex_ctrl_q.reg_write;
    assign MemToReg   = ex_ctrl_q.mem_to_reg;
    assign MemWrite   = ex_ctrl_q.mem_write;
    assign loadSign   = ex_ctrl_q.load_sign;
    assign mul        = ex_ctrl_q.mul;
    assign extOp      = ex_ctrl_q.ext_op;
    assign LHIOp      = ex_ctrl_q.lhi_op;
    assign DSize      = ex_ctrl_q.dsize;
    assign ALUCtrl    = ex_ctrl_q.alu_ctrl;
    assign ex_dest    = ex_dest_q;
    assign ex_rs1     = ex_rs1_q;
    assign ex_rs2     = ex_rs2_q;

endmodule

// File: tb/tb_dlx_id_control.sv
// Bench for dlx_id_control: three configurations (default, no interlock,
// single-cycle multiply) run side by side against a behavioural model.
module tb_dlx_id_control;

    typedef struct packed {
        logic       valid;
        logic       pc_to_reg;
        logic       reg_to_pc;
        logic       jump;
        logic       branch;
        logic       branch_zero;
        logic       r_type;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       load_sign;
        logic       mul;
        logic       ext_op;
        logic       lhi_op;
        logic [1:0] dsize;
        logic [3:0] alu;
        logic [4:0] dest;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ex_t;

    localparam logic [5:0] OPS [36] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h01, 6'h02, 6'h03,
        6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h12,
        6'h13, 6'h14, 6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D, 6'h20,
        6'h21, 6'h23, 6'h23, 6'h24, 6'h25, 6'h28, 6'h2B};
    localparam logic [5:0] FUNCS [16] = '{6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
        6'h23, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_instr = '0;
    logic        id_valid = 1'b0;
    logic        ex_taken = 1'b0;

    logic [34:0] obs [3];
    logic        busy_o [3];
    logic        stall_o [3];

    ex_t  m_ex [3];
    int   m_busy [3];
    logic pre_stall [3];
    logic exp_stall [3];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       st, mb, v, pc, rp, jp, br, bz, rt, rw, mr, mw, ls, ml, eo, lh;
        logic [0:1] ds;
        logic [0:3] alu;
        logic [0:4] dst, s1, s2;
        dlx_id_control #(
            .MUL_CYCLES(g == 2 ? 1 : 4),
            .HAZARD_EN (g == 1 ? 1'b0 : 1'b1)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
            .ex_taken(ex_taken), .if_stall(st), .mul_busy(mb), .ex_valid(v),
            .PCtoReg(pc), .regToPC(rp), .jump(jp), .branch(br), .branchZero(bz),
            .RType(rt), .RegWrite(rw), .MemToReg(mr), .MemWrite(mw), .loadSign(ls),
            .mul(ml), .extOp(eo), .LHIOp(lh), .DSize(ds), .ALUCtrl(alu),
            .ex_dest(dst), .ex_rs1(s1), .ex_rs2(s2)
        );
        assign obs[g]     = {v, pc, rp, jp, br, bz, rt, rw, mr, mw, ls, ml, eo, lh, ds, alu, dst, s1, s2};
        assign busy_o[g]  = mb;
        assign stall_o[g] = st;
    end

    function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] a, logic [4:0] b, logic [15:0] imm);
        return {op, a, b, imm};
    endfunction

    function automatic logic [31:0] rtype(logic [5:0] op, logic [4:0] a, logic [4:0] b, logic [4:0] d, logic [5:0] fn);
        return {op, a, b, d, 5'd0, fn};
    endfunction

    function automatic logic [3:0] r_alu(logic [5:0] fn);
        case (fn)
            6'h04: return 4'b1001;  6'h06: return 4'b1010;  6'h07: return 4'b0111;
            6'h22, 6'h23: return 4'b0001;
            6'h24: return 4'b1101;  6'h25: return 4'b1110;  6'h26: return 4'b1111;
            6'h28: return 4'b1011;  6'h29: return 4'b1100;  6'h2A: return 4'b0010;
            6'h2B: return 4'b0100;  6'h2C: return 4'b0011;  6'h2D: return 4'b0101;
            default: return 4'b0000;
        endcase
    endfunction

    // {is immediate ALU op, sign-extend, ALU code}
    function automatic logic [5:0] imm_info(logic [5:0] op);
        case (op)
            6'h08: return 6'b11_0000;  6'h09: return 6'b10_0000;  6'h0A: return 6'b11_0001;
            6'h0B: return 6'b10_0001;  6'h0C: return 6'b10_1101;  6'h0D: return 6'b10_1110;
            6'h0E: return 6'b10_1111;  6'h0F: return 6'b10_0000;  6'h14: return 6'b10_1001;
            6'h16: return 6'b10_1010;  6'h17: return 6'b10_0111;  6'h18: return 6'b11_1011;
            6'h19: return 6'b11_1100;  6'h1A: return 6'b11_0010;  6'h1B: return 6'b11_0100;
            6'h1C: return 6'b11_0011;  6'h1D: return 6'b11_0101;
            default: return 6'b00_0000;
        endcase
    endfunction

    function automatic logic [1:0] mem_size(logic [5:0] op);
        if (op[1:0] == 2'b00) return 2'b01;
        if (op[1:0] == 2'b01) return 2'b10;
        return 2'b11;
    endfunction

    function automatic ex_t ref_decode(logic [31:0] ins, logic v);
        ex_t d;
        logic [5:0] op, info;
        op = ins[31:26];
        info = imm_info(op);
        d = '0;
        d.valid = v;
        d.rs1 = ins[25:21];
        d.rs2 = ins[20:16];
        if (op == 6'h00 || op == 6'h01) begin
            d.r_type = 1'b1; d.reg_write = 1'b1; d.dest = ins[15:11];
            if (op == 6'h00) d.alu = r_alu(ins[5:0]);
            else d.mul = (ins[4:0] == 5'h0E) || (ins[4:0] == 5'h16);
        end else if (op == 6'h02 || op == 6'h03 || op == 6'h12 || op == 6'h13) begin
            d.jump = 1'b1;
            d.reg_to_pc = op[4];
            d.pc_to_reg = op[0];
            d.reg_write = op[0];
            d.dest = op[0] ? 5'd31 : 5'd0;
        end else if (op == 6'h04 || op == 6'h05) begin
            d.branch = 1'b1; d.branch_zero = (op == 6'h04); d.ext_op = 1'b1;
        end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
            d.reg_write = 1'b1; d.mem_to_reg = 1'b1; d.ext_op = 1'b1; d.dest = ins[20:16];
            d.load_sign = (op inside {6'h20, 6'h21, 6'h23});
            d.dsize = mem_size(op);
        end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
            d.mem_write = 1'b1; d.ext_op = 1'b1; d.dsize = mem_size(op);
        end else if (info[5]) begin
            d.reg_write = 1'b1; d.dest = ins[20:16]; d.ext_op = info[4]; d.alu = info[3:0];
            d.lhi_op = (op == 6'h0F);
        end
        if (!v) begin
            d.reg_write = 1'b0; d.mem_write = 1'b0; d.jump = 1'b0; d.branch = 1'b0;
        end
        return d;
    endfunction

    function automatic logic m_hazard(int k, logic [31:0] ins, logic v);
        logic [5:0] op;
        logic u1, u2;
        op = ins[31:26];
        u1 = !(op == 6'h02 || op == 6'h03 || op == 6'h0F);
        u2 = (op == 6'h00 || op == 6'h01 || op inside {6'h28, 6'h29, 6'h2B});
        return (k != 1) && m_ex[k].valid && m_ex[k].mem_to_reg && v && (m_ex[k].dest != 5'd0) &&
               ((u1 && ins[25:21] == m_ex[k].dest) || (u2 && ins[20:16] == m_ex[k].dest));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ex[k] = '0;
            m_busy[k] = 0;
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic v, input logic tk);
        logic hz [3];
        @(negedge clk);
        id_instr = ins; id_valid = v; ex_taken = tk;
        #1;
        for (int k = 0; k < 3; k++) begin
            hz[k] = m_hazard(k, ins, v);
            pre_stall[k] = stall_o[k];
            exp_stall[k] = (m_busy[k] != 0) || (hz[k] && !tk);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (m_busy[k] != 0) m_busy[k]--;
            else if (tk || hz[k]) m_ex[k] = '0;
            else begin
                m_ex[k] = ref_decode(ins, v);
                if (v && m_ex[k].mul) m_busy[k] = (k == 2 ? 1 : 4) - 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; id_valid = 1'b0; ex_taken = 1'b0; id_instr = '0;
        model_reset();
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ex_t o;
        #3;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (obs[k] !== 35'd0 || busy_o[k] !== 1'b0 || stall_o[k] !== 1'b0) begin
                n_err++; $display("FAIL reset_init dut%0d: got %h/%b/%b want 0", k, obs[k], busy_o[k], stall_o[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(itype(6'h23, 5'd1, 5'd5, 16'd0), 1'b1, 1'b0);
        id_instr = rtype(6'h00, 5'd5, 5'd2, 5'd6, 6'h20); id_valid = 1'b1;
        #1;
        n_vec++;
        if (stall_o[0] !== 1'b1) begin n_err++; $display("FAIL pre_reset_stall: got %b want 1", stall_o[0]); end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (obs[0] !== 35'd0 || stall_o[0] !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got %h stall %b want 0", obs[0], stall_o[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(itype(6'h08, 5'd1, 5'd4, 16'd7), 1'b1, 1'b0);
        o = obs[0];
        n_vec++;
        if (o.valid !== 1'b1 || o.dest !== 5'd4) begin
            n_err++; $display("FAIL reset_release: got valid %b dest %0d want 1/4", o.valid, o.dest);
        end
    endtask

    task automatic test_alu_decode();
        ex_t o;
        do_reset();
        step(itype(6'h08, 5'd1, 5'd2, 16'd5), 1'b1, 1'b0);
        o = obs[0];
        n_vec++;
        if (o.alu !== 4'b0000 || o.ext_op !== 1'b1) begin n_err++; $display("FAIL addi: got alu %b ext %b want 0000/1", o.alu, o.ext_op); end
        step(rtype(6'h00, 5'd1, 5'd2, 5'd3, 6'h26), 1'b1, 1'b0);
        o = obs[0];
        n_vec++;
        if (o.alu !== 4'b1111 || o.reg_write !== 1'b1 || o.dest !== 5'd3) begin
            n_err++; $display("FAIL xor: got alu %b rw %b dest %0d want 1111/1/3", o.alu, o.reg_write, o.dest);
        end
        step(itype(6'h16, 5'd1, 5'd2, 16'd3), 1'b1, 1'b0);
        o = obs[0];
        n_vec++;
        if (o.alu !== 4'b1010) begin n_err++; $display("FAIL srli: got alu %b want 1010", o.alu); end
        step(itype(6'h0B, 5'd1, 5'd2, 16'd3), 1'b1, 1'b0);
        o = obs[0];
        n_vec++;
        if (o.alu !== 4'b0001 || o.ext_op !== 1'b0) begin n_err++; $display("FAIL subui: got alu %b ext %b want 0001/0", o.alu, o.ext_op); end
    endtask

    task automatic test_load_use();
        ex_t o0, o1;
        do_reset();
        step(itype(6'h23, 5'd1, 5'd5, 16'd0), 1'b1, 1'b0);
        step(rtype(6'h00, 5'd5, 5'd2, 5'd6, 6'h20), 1'b1, 1'b0);
        o0 = obs[0]; o1 = obs[1];
        n_vec++;
        if (pre_stall[0] !== 1'b1 || o0.valid !== 1'b0) begin
            n_err++; $display("FAIL load_use_bubble: got stall %b valid %b want 1/0", pre_stall[0], o0.valid);
        end
        n_vec++;
        if (pre_stall[1] !== 1'b0 || o1.valid !== 1'b1 || o1.dest !== 5'd6) begin
            n_err++; $display("FAIL no_interlock: got stall %b valid %b dest %0d want 0/1/6", pre_stall[1], o1.valid, o1.dest);
        end
        step(rtype(6'h00, 5'd5, 5'd2, 5'd6, 6'h20), 1'b1, 1'b0);
        o0 = obs[0];
        n_vec++;
        if (pre_stall[0] !== 1'b0 || o0.valid !== 1'b1 || o0.dest !== 5'd6) begin
            n_err++; $display("FAIL load_use_issue: got stall %b valid %b dest %0d want 0/1/6", pre_stall[0], o0.valid, o0.dest);
        end
        step(itype(6'h23, 5'd1, 5'd0, 16'd0), 1'b1, 1'b0);
        step(rtype(6'h00, 5'd0, 5'd2, 5'd6, 6'h20), 1'b1, 1'b0);
        o0 = obs[0];
        n_vec++;
        if (pre_stall[0] !== 1'b0 || o0.valid !== 1'b1) begin
            n_err++; $display("FAIL load_r0: got stall %b valid %b want 0/1", pre_stall[0], o0.valid);
        end
    endtask

    task automatic test_multiply();
        ex_t o;
        int busy_cnt;
        do_reset();
        step(rtype(6'h01, 5'd1, 5'd2, 5'd3, 6'h0E), 1'b1, 1'b0);
        busy_cnt = (busy_o[0] === 1'b1) ? 1 : 0;
        n_vec++;
        if (busy_o[2] !== 1'b0) begin n_err++; $display("FAIL mul1_busy: got %b want 0", busy_o[2]); end
        for (int i = 1; i <= 4; i++) begin
            step(rtype(6'h00, 5'd1, 5'd2, 5'd7, 6'h20), 1'b1, 1'b0);
            o = obs[0];
            if (busy_o[0] === 1'b1) busy_cnt++;
            n_vec++;
            if (pre_stall[0] !== (i < 4) || o.mul !== (i < 4) || o.dest !== ((i < 4) ? 5'd3 : 5'd7)) begin
                n_err++; $display("FAIL mul_hold step %0d: got stall %b mul %b dest %0d", i, pre_stall[0], o.mul, o.dest);
            end
            if (i == 1) begin
                o = obs[2];
                n_vec++;
                if (o.dest !== 5'd7 || pre_stall[2] !== 1'b0) begin
                    n_err++; $display("FAIL mul1_next: got dest %0d stall %b want 7/0", o.dest, pre_stall[2]);
                end
            end
        end
        n_vec++;
        if (busy_cnt != 3) begin n_err++; $display("FAIL mul_busy_cycles: got %0d want 3", busy_cnt); end
        do_reset();
        step(rtype(6'h01, 5'd1, 5'd2, 5'd3, 6'h16), 1'b1, 1'b0);
        step(rtype(6'h00, 5'd1, 5'd2, 5'd7, 6'h20), 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (busy_o[0] !== 1'b0 || stall_o[0] !== 1'b0) begin
            n_err++; $display("FAIL mul_reset: got busy %b stall %b want 0/0", busy_o[0], stall_o[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_squash();
        ex_t o;
        do_reset();
        step(itype(6'h23, 5'd1, 5'd5, 16'd0), 1'b1, 1'b0);
        step(rtype(6'h00, 5'd5, 5'd2, 5'd6, 6'h20), 1'b1, 1'b1);
        n_vec++;
        if (pre_stall[0] !== 1'b0 || obs[0] !== 35'd0) begin
            n_err++; $display("FAIL squash: got stall %b ex %h want 0/0", pre_stall[0], obs[0]);
        end
        step(itype(6'h08, 5'd1, 5'd9, 16'd4), 1'b1, 1'b0);
        o = obs[0];
        n_vec++;
        if (o.valid !== 1'b1 || o.dest !== 5'd9) begin
            n_err++; $display("FAIL squash_target: got valid %b dest %0d want 1/9", o.valid, o.dest);
        end
    endtask

    task automatic test_links();
        ex_t o;
        do_reset();
        step({6'h03, 26'h0ABCDE}, 1'b1, 1'b0);
        o = obs[0];
        n_vec++;
        if (o.dest !== 5'd31 || o.pc_to_reg !== 1'b1 || o.reg_write !== 1'b1) begin
            n_err++; $display("FAIL jal: got dest %0d pctoreg %b rw %b want 31/1/1", o.dest, o.pc_to_reg, o.reg_write);
        end
        step(itype(6'h12, 5'd3, 5'd0, 16'd0), 1'b1, 1'b0);
        o = obs[0];
        n_vec++;
        if (o.reg_write !== 1'b0 || o.reg_to_pc !== 1'b1 || o.jump !== 1'b1) begin
            n_err++; $display("FAIL jr: got rw %b regtopc %b jump %b want 0/1/1", o.reg_write, o.reg_to_pc, o.jump);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [5:0]  op;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            op = ($urandom_range(0, 19) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 35)];
            ins = $urandom;
            ins[31:26] = op;
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            if (op == 6'h00 && $urandom_range(0, 3) != 0) ins[5:0] = FUNCS[$urandom_range(0, 15)];
            if (op == 6'h01 && $urandom_range(0, 1) == 0) ins[4:0] = ($urandom_range(0, 1) == 0) ? 5'h0E : 5'h16;
            step(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (pre_stall[k] !== exp_stall[k]) begin
                    n_err++; $display("FAIL rand_stall dut%0d cyc %0d: got %b want %b", k, i, pre_stall[k], exp_stall[k]);
                end
                n_vec++;
                if (obs[k] !== m_ex[k]) begin
                    n_err++; $display("FAIL rand_ex dut%0d cyc %0d: got %h want %h", k, i, obs[k], m_ex[k]);
                end
                n_vec++;
                if (busy_o[k] !== (m_busy[k] != 0)) begin
                    n_err++; $display("FAIL rand_busy dut%0d cyc %0d: got %b want %b", k, i, busy_o[k], m_busy[k] != 0);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_alu_decode();
        test_load_use();
        test_multiply();
        test_squash();
        test_links();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
